ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- AHB-Lite single-transfer initiator: turns a simple valid/ready command port into one 32-bit NONSEQ read or write on the AHB bus, then returns one response per command.
- Drives the same register-block slaves the MCU normally drives, e.g. the game-control register block at offsets 0x0/0x4/0x8/0xC. Gives hardware sequencers and test logic bus access without the MCU.

Parameters:
- TIMEOUT, 256, consecutive HREADY-low cycles in the data phase before the transfer is abandoned with a timeout error; 0 disables the timeout.
- HPROT_VAL, 4'b0011, constant value driven on AHB_HPROT.

Ports:
- AHB_HCLK  in  1  bus clock, single clock domain
- AHB_HRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_error  out  1  slave ERROR response, misaligned address, or timeout
- rsp_timeout  out  1  error cause was timeout
- AHB_HSEL  out  1  slave select, asserted with the address phase
- AHB_HTRANS  out  2  IDLE = 00, NONSEQ = 10
- AHB_HADDR  out  32  transfer address
- AHB_HWRITE  out  1  transfer direction
- AHB_HSIZE  out  3  constant 3'b010 (word)
- AHB_HBURST  out  3  constant 3'b000 (SINGLE)
- AHB_HPROT  out  4  constant HPROT_VAL
- AHB_HMASTLOCK  out  1  constant 0
- AHB_HWDATA  out  32  write data, valid in the data phase
- AHB_HRDATA  in  32  read data
- AHB_HREADY  in  1  transfer ready
- AHB_HRESP  in  2  00 = OKAY, 01 = ERROR

Behaviour:
- Reset values: cmd_ready=0 while reset is asserted, 1 after release; all rsp_* =0; AHB_HSEL=0; AHB_HTRANS=00; AHB_HADDR=0; AHB_HWRITE=0; AHB_HWDATA=0.
- All outputs are registered except cmd_ready, which is decoded from the state.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture cmd_write, cmd_addr and cmd_wdata.
  - If cmd_addr[1:0]!=0, go to RESP with rsp_error=1. No bus transfer is issued.
  - Otherwise go to ADDR.
- ADDR:
  - Drive HSEL=1, HTRANS=10, HADDR, HWRITE.
  - On HREADY=1 go to DATA.
  - While HREADY=0, hold all address-phase signals stable.
- DATA:
  - Drive HTRANS=00, HSEL=0, HWDATA=captured data.
  - On HREADY=1 with HRESP=00, capture HRDATA (reads only) and go to RESP.
  - On HREADY=1 with HRESP=01, set rsp_error=1, set rdata=0, go to RESP.
  - The first ERROR cycle has HREADY=0. Nothing extra is required, because HTRANS is already IDLE.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. cmd_ready=0 in ADDR, DATA and RESP.
- Latency with zero wait states: command accepted at edge T0, address phase T1, data phase T2, rsp_valid high in cycle T3. Each wait state adds one cycle. The next command can be accepted in the cycle after rsp_valid, so the minimum spacing is 4 cycles.
- Timeout:
  - A stall counter clears on entry to DATA and increments each HREADY-low cycle, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT (and TIMEOUT≠0): go to RESP with rsp_error=1 and rsp_timeout=1, and drive the bus idle.
  - The counter is inactive in ADDR, so the address phase waits indefinitely.
- rsp_timeout=1 always implies rsp_error=1.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately, the bus goes idle, and no response is issued.
- Commands presented while cmd_ready=0 are ignored. cmd_* is sampled only on the accept edge.

Test Plan:
- Write 0x000000A5 to 0x0000_0004 with HREADY always 1 → NONSEQ/HWRITE=1/HADDR=0x4 in cycle T1, HWDATA=0xA5 in T2, rsp_valid in T3, rsp_error=0.
- Read 0x0000_000C; slave returns 0x00001234 after 3 HREADY-low cycles in the data phase → rsp_valid in T6, rsp_rdata=0x1234.
- Slave answers a read with a 2-cycle ERROR (HRESP=01: HREADY 0, then 1) → rsp_error=1, rsp_rdata=0, rsp_timeout=0, HTRANS=00 throughout.
- cmd_addr=0x0000_0006 → no HTRANS activity, rsp_valid 1 cycle after accept, rsp_error=1.
- TIMEOUT=8, HREADY held low in the data phase → rsp_error=1 and rsp_timeout=1 exactly 8 cycles after entering DATA; the next command is accepted normally.
- Assert AHB_HRESET during ADDR → HTRANS=00 and HSEL=0 asynchronously, no rsp_valid; after release cmd_ready=1 and a back-to-back write/read to 0x0 returns the written value.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator: one valid/ready command becomes one
// 32-bit NONSEQ read or write, followed by a one-cycle response strobe.
module ahb_lite_master #(
    parameter int         TIMEOUT   = 256,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        AHB_HCLK,
    input  logic        AHB_HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        AHB_HSEL,
    output logic [1:0]  AHB_HTRANS,
    output logic [31:0] AHB_HADDR,
    output logic        AHB_HWRITE,
    output logic [2:0]  AHB_HSIZE,
    output logic [2:0]  AHB_HBURST,
    output logic [3:0]  AHB_HPROT,
    output logic        AHB_HMASTLOCK,
    output logic [31:0] AHB_HWDATA,
    input  logic [31:0] AHB_HRDATA,
    input  logic        AHB_HREADY,
    input  logic [1:0]  AHB_HRESP
);

    localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   TO_MAX  = CW'(TIMEOUT);
    localparam logic [1:0]      HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]      HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    state_t        state_r, state_s;
    logic          hsel_r, hsel_s;
    logic [1:0]    htrans_r, htrans_s;
    logic [31:0]   haddr_r, haddr_s;
    logic          hwrite_r, hwrite_s;
    logic [31:0]   hwdata_r, hwdata_s;
    logic [31:0]   wdata_r, wdata_s;
    logic [CW-1:0] stall_cnt_r, stall_cnt_s;
    logic          rsp_valid_r, rsp_valid_s;
    logic [31:0]   rsp_rdata_r, rsp_rdata_s;
    logic          rsp_error_r, rsp_error_s;
    logic          rsp_timeout_r, rsp_timeout_s;

    // Next-state and next-output decode; response fields are only non-zero while rsp_valid is high.
    always_comb begin
        state_s       = state_r;
        hsel_s        = hsel_r;
        htrans_s      = htrans_r;
        haddr_s       = haddr_r;
        hwrite_s      = hwrite_r;
        hwdata_s      = hwdata_r;
        wdata_s       = wdata_r;
        stall_cnt_s   = stall_cnt_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = 32'h0000_0000;
        rsp_error_s   = 1'b0;
        rsp_timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    wdata_s  = cmd_wdata;
                    hwrite_s = cmd_write;
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_error_s = 1'b1;
                    end else begin
                        state_s  = ST_ADDR;
                        haddr_s  = cmd_addr;
                        hsel_s   = 1'b1;
                        htrans_s = HTRANS_NONSEQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (AHB_HREADY) begin
                    state_s     = ST_DATA;
                    hsel_s      = 1'b0;
                    htrans_s    = HTRANS_IDLE;
                    hwdata_s    = wdata_r;
                    stall_cnt_s = {CW{1'b0}};
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (AHB_HREADY) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    if (AHB_HRESP != 2'b00) begin
                        rsp_error_s = 1'b1;
                    end else if (!hwrite_r) begin
                        rsp_rdata_s = AHB_HRDATA;
                    end else begin
                        rsp_rdata_s = 32'h0000_0000;
                    end
                end else if ((TIMEOUT != 0) && (stall_cnt_r == TO_LAST)) begin
                    // This low cycle is the TIMEOUT-th one: abandon the transfer.
                    state_s       = ST_RESP;
                    rsp_valid_s   = 1'b1;
                    rsp_error_s   = 1'b1;
                    rsp_timeout_s = 1'b1;
                    hsel_s        = 1'b0;
                    htrans_s      = HTRANS_IDLE;
                end else if ((TIMEOUT != 0) && (stall_cnt_r != TO_MAX)) begin
                    stall_cnt_s = stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    stall_cnt_s = stall_cnt_r;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                hsel_s   = 1'b0;
                htrans_s = HTRANS_IDLE;
            end
        endcase
    end

    // State and registered bus/response outputs.
    always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
        if (AHB_HRESET) begin
            state_r       <= ST_IDLE;
            hsel_r        <= 1'b0;
            htrans_r      <= HTRANS_IDLE;
            haddr_r       <= 32'h0000_0000;
            hwrite_r      <= 1'b0;
            hwdata_r      <= 32'h0000_0000;
            wdata_r       <= 32'h0000_0000;
            stall_cnt_r   <= {CW{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            hsel_r        <= hsel_s;
            htrans_r      <= htrans_s;
            haddr_r       <= haddr_s;
            hwrite_r      <= hwrite_s;
            hwdata_r      <= hwdata_s;
            wdata_r       <= wdata_s;
            stall_cnt_r   <= stall_cnt_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_error_r   <= rsp_error_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

    assign cmd_ready     = (state_r == ST_IDLE) && !AHB_HRESET;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_error     = rsp_error_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign AHB_HSEL      = hsel_r;
    assign AHB_HTRANS    = htrans_r;
    assign AHB_HADDR     = haddr_r;
    assign AHB_HWRITE    = hwrite_r;
    assign AHB_HWDATA    = hwdata_r;
    assign AHB_HSIZE     = 3'b010;
    assign AHB_HBURST    = 3'b000;
    assign AHB_HPROT     = HPROT_VAL;
    assign AHB_HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master: a scripted slave plus a word-memory
// reference model predicting bus activity, response timing and response data.
module tb_ahb_lite_master;

    localparam int TO = 8;

    logic        AHB_HCLK = 1'b0;
    logic        AHB_HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        AHB_HSEL, AHB_HWRITE, AHB_HMASTLOCK, AHB_HREADY;
    logic [1:0]  AHB_HTRANS, AHB_HRESP;
    logic [31:0] AHB_HADDR, AHB_HWDATA, AHB_HRDATA;
    logic [2:0]  AHB_HSIZE, AHB_HBURST;
    logic [3:0]  AHB_HPROT;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];

    ahb_lite_master #(.TIMEOUT(TO), .HPROT_VAL(4'b0011)) dut (
        .AHB_HCLK(AHB_HCLK), .AHB_HRESET(AHB_HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .AHB_HSEL(AHB_HSEL), .AHB_HTRANS(AHB_HTRANS), .AHB_HADDR(AHB_HADDR),
        .AHB_HWRITE(AHB_HWRITE), .AHB_HSIZE(AHB_HSIZE), .AHB_HBURST(AHB_HBURST),
        .AHB_HPROT(AHB_HPROT), .AHB_HMASTLOCK(AHB_HMASTLOCK), .AHB_HWDATA(AHB_HWDATA),
        .AHB_HRDATA(AHB_HRDATA), .AHB_HREADY(AHB_HREADY), .AHB_HRESP(AHB_HRESP)
    );

    always #5 AHB_HCLK = ~AHB_HCLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One command: aw = address-phase wait states, dw = HREADY-low data cycles,
    // err = slave answers with a two-cycle ERROR; dw >= TO means a stalled slave.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int aw, input int dw_in, input bit err_in);
        int dw, exp_lat, d;
        bit err, mis, tmo, ok;
        logic [31:0] exp_rd;
        logic [3:0]  idx;
        dw  = dw_in;
        err = err_in;
        mis = (addr[1:0] != 2'b00);
        idx = addr[5:2];
        tmo = !mis && (dw >= TO);
        if (tmo) err = 1'b0;
        if (err && dw == 0) dw = 1;
        ok = !mis && !tmo && !err;
        if (mis)      exp_lat = 1;
        else if (tmo) exp_lat = aw + TO + 2;
        else          exp_lat = aw + dw + 3;
        exp_rd = (ok && !wr) ? ref_mem[idx] : 32'h0;
        if (ok && wr) ref_mem[idx] = wd;

        @(posedge AHB_HCLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        @(negedge AHB_HCLK);
        check_eq("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rsp_idle", {31'd0, rsp_valid}, 32'd0);

        for (int c = 1; c <= exp_lat; c++) begin
            @(posedge AHB_HCLK); #1;
            // Garbage on the command port while busy must be ignored.
            cmd_valid  = (c < exp_lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_write  = 1'($urandom);
            cmd_addr   = $urandom;
            cmd_wdata  = $urandom;
            AHB_HREADY = 1'b1;
            AHB_HRESP  = 2'b00;
            AHB_HRDATA = $urandom;
            if (!mis && c < exp_lat) begin
                if (c <= aw) begin
                    AHB_HREADY = 1'b0;
                end else if (c > aw + 1) begin
                    d = c - aw - 1;
                    if (tmo || d <= dw) begin
                        AHB_HREADY = 1'b0;
                        AHB_HRESP  = (err && d == dw) ? 2'b01 : 2'b00;
                    end else begin
                        AHB_HRESP = err ? 2'b01 : 2'b00;
                        if (ok && !wr) AHB_HRDATA = slv_mem[idx];
                    end
                end
            end
            @(negedge AHB_HCLK);
            if (!mis && c <= aw + 1) begin
                check_eq("htrans_addr", {30'd0, AHB_HTRANS}, 32'h2);
                check_eq("hsel_addr",   {31'd0, AHB_HSEL}, 32'd1);
                check_eq("haddr",       AHB_HADDR, addr);
                check_eq("hwrite",      {31'd0, AHB_HWRITE}, {31'd0, wr});
            end else begin
                check_eq("htrans_idle", {30'd0, AHB_HTRANS}, 32'h0);
                check_eq("hsel_idle",   {31'd0, AHB_HSEL}, 32'd0);
            end
            if (!mis && wr && c > aw + 1 && c < exp_lat)
                check_eq("hwdata", AHB_HWDATA, wd);
            if (ok && wr && c == exp_lat - 1)
                slv_mem[idx] = AHB_HWDATA;
            check_eq("rsp_valid", {31'd0, rsp_valid}, {31'd0, (c == exp_lat)});
            if (c == exp_lat) begin
                check_eq("rsp_rdata",   rsp_rdata, exp_rd);
                check_eq("rsp_error",   {31'd0, rsp_error}, {31'd0, !ok});
                check_eq("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, tmo});
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        AHB_HRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        AHB_HREADY = 1'b1; AHB_HRESP = 2'b00; AHB_HRDATA = 32'h0;
        #12;
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_htrans",    {30'd0, AHB_HTRANS}, 32'd0);
        check_eq("rst_hsel",      {31'd0, AHB_HSEL}, 32'd0);
        check_eq("rst_haddr",     AHB_HADDR, 32'd0);
        check_eq("rst_hwdata",    AHB_HWDATA, 32'd0);
        check_eq("hsize",         {29'd0, AHB_HSIZE}, 32'h2);
        check_eq("hburst",        {29'd0, AHB_HBURST}, 32'h0);
        check_eq("hprot",         {28'd0, AHB_HPROT}, 32'h3);
        check_eq("hmastlock",     {31'd0, AHB_HMASTLOCK}, 32'h0);
        @(negedge AHB_HCLK);
        AHB_HRESET = 1'b0;
        @(negedge AHB_HCLK);
        check_eq("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Directed cases.
        do_cmd(1'b1, 32'h4, 32'h0000_00A5, 0, 0, 1'b0);
        ref_mem[3] = 32'h0000_1234;
        slv_mem[3] = 32'h0000_1234;
        do_cmd(1'b0, 32'hC, 32'h0, 0, 3, 1'b0);
        do_cmd(1'b0, 32'h8, 32'h0, 0, 1, 1'b1);
        do_cmd(1'b1, 32'h6, 32'h5555_AAAA, 0, 0, 1'b0);
        do_cmd(1'b0, 32'h10, 32'h0, 0, TO, 1'b0);
        do_cmd(1'b1, 32'h10, 32'hCAFE_F00D, 2, 0, 1'b0);
        do_cmd(1'b0, 32'h4, 32'h0, 0, 0, 1'b0);

        // Reset asserted during the address phase.
        @(posedge AHB_HCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hDEAD_BEEF;
        @(posedge AHB_HCLK); #1;
        cmd_valid = 1'b0; AHB_HREADY = 1'b0;
        @(negedge AHB_HCLK);
        check_eq("pre_rst_htrans", {30'd0, AHB_HTRANS}, 32'h2);
        #2 AHB_HRESET = 1'b1;
        #1;
        check_eq("async_htrans", {30'd0, AHB_HTRANS}, 32'h0);
        check_eq("async_hsel",   {31'd0, AHB_HSEL}, 32'd0);
        check_eq("async_ready",  {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge AHB_HCLK);
            check_eq("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        AHB_HRESET = 1'b0;
        AHB_HREADY = 1'b1;
        @(negedge AHB_HCLK);
        check_eq("ready_after_mid_rst", {31'd0, cmd_ready}, 32'd1);
        do_cmd(1'b1, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0);
        do_cmd(1'b0, 32'h0, 32'h0, 0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_cmd(1'($urandom), a, $urandom, $urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 5),
                   ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
